iq_word_packer: RTL
===================

# iq_word_packer

Packs a time-interleaved stream of real/imag samples (real first) into one complex word {real, imag} of WIDTH_IN_WORD bits. It sits directly upstream of wordSplitter, whose RIword_i is driven from RIword_o. The block adds valid/ready flow control, a 2-entry output FIFO and start-of-frame realignment. Half-word MSBs carry the real part; LSBs carry the imaginary part.

## Interface
- WIDTH_IN_WORD, 32, output complex word width; must be even and ≥ 4; sample width SW = WIDTH_IN_WORD>>1
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  asynchronous, active-high reset
- clr_i  in  1  synchronous clear: flush FIFO, return to WAIT_RE; priority over all other inputs
- sample_i  in  SW  input sample (real or imag according to phase)
- sample_valid_i  in  1  sample_i valid
- sof_i  in  1  qualifies sample_i as a real part (frame/pair start); sampled only on accept
- sample_ready_o  out  1  block accepts sample_i this cycle
- RIword_o  out  WIDTH_IN_WORD  FIFO head, {real[SW-1:0], imag[SW-1:0]}
- RIword_valid_o  out  1  FIFO not empty
- RIword_ready_i  in  1  downstream consumes head
- phase_o  out  1  0 = expecting real (WAIT_RE), 1 = expecting imag (WAIT_IM)
- realign_o  out  1  registered 1-cycle pulse: held real discarded by sof_i

## Operation
- Accept = sample_valid_i & sample_ready_o. Pop = RIword_valid_o & RIword_ready_i.
- FSM, 2 states:
  - WAIT_RE: on accept, sample_i → real holding register, go WAIT_IM. sof_i is ignored.
  - WAIT_IM, accept with sof_i=1: sample_i overwrites the real holding register; stay WAIT_IM; realign_o=1 next cycle.
  - WAIT_IM, accept with sof_i=0: push {real_hold, sample_i} into FIFO; go WAIT_RE.
- sample_ready_o = (state==WAIT_RE) | (count<2). count is registered, so there is no combinational path from RIword_ready_i to sample_ready_o.
- FIFO: 2 entries, in-order. A push and a pop in the same cycle at count 2 cannot occur, because ready is already low. A push and a pop at count 1 keeps count at 1.
- clr_i: count←0, state←WAIT_RE, realign_o←0. The real holding register keeps its value, but it is don't-care.
- Reset values: state WAIT_RE, count 0, RIword_o 0, RIword_valid_o 0, phase_o 0, realign_o 0, sample_ready_o 1 (combinational from state).

## Timing
- Imag accepted at cycle N with the FIFO empty: RIword_valid_o=1 and the word appears from cycle N+1.
- Peak throughput: 1 word per 2 accepted samples; sustained at full input rate while RIword_ready_i=1.
- Head stability: RIword_o and RIword_valid_o hold until popped; they never change while valid & ~ready.
- realign_o: high exactly 1 cycle, the cycle after the accepting edge.
- Reset asserted mid-pair or with a full FIFO: all contents are lost immediately (asynchronously) and the block restarts in WAIT_RE.

## Configuration
- IQPACK_ERRCNT_EN defined: adds output errcnt_o (out, 8 bits). It increments once per realign event, saturates at 255, and is cleared by rst_i and clr_i. A realign in the same cycle as clr_i does not count.
- IQPACK_ERRCNT_EN undefined: port and counter are absent; all other behaviour is identical.

## Test plan
- Reset, then send samples 0x1111, 0x2222 with RIword_ready_i=1 (W=32): RIword_o=0x11112222, valid for 1 cycle starting 1 cycle after the second accept; phase_o toggles 0→1→0.
- Hold RIword_ready_i=0 and send 6 samples: 2 words are stored, sample_ready_o drops in WAIT_IM after the 5th accept, and the head is stable. Release ready: words pop in order, ready returns.
- Send 0xAAAA, then 0xBBBB with sof_i=1, then 0xCCCC: a single word 0xBBBBCCCC is produced, realign_o pulses once (errcnt_o=1 when enabled).
- 300 consecutive realigns with IQPACK_ERRCNT_EN: errcnt_o saturates at 255, then clr_i → 0.
- Assert clr_i during WAIT_IM with 1 word queued: next cycle valid=0, phase_o=0. The following pair packs correctly.
- Assert rst_i asynchronously mid-cycle with the FIFO full: outputs go to reset values before the next edge, and sample_ready_o=1.

Source files
------------

// File: rtl/iq_word_packer_if.sv
// Sample-in / complex-word-out handshake bundle for iq_word_packer.
// master = stimulus/downstream side, slave = the packer itself.
interface iq_word_packer_if #(
  parameter int WIDTH_IN_WORD = 32
);
  localparam int SW = WIDTH_IN_WORD >> 1;

  logic [SW-1:0]            sample_i;
  logic                     sample_valid_i;
  logic                     sof_i;
  logic                     sample_ready_o;
  logic [WIDTH_IN_WORD-1:0] RIword_o;
  logic                     RIword_valid_o;
  logic                     RIword_ready_i;
  logic                     phase_o;
  logic                     realign_o;

  modport master (
    output sample_i, sample_valid_i, sof_i, RIword_ready_i,
    input  sample_ready_o, RIword_o, RIword_valid_o, phase_o, realign_o
  );

  modport slave (
    input  sample_i, sample_valid_i, sof_i, RIword_ready_i,
    output sample_ready_o, RIword_o, RIword_valid_o, phase_o, realign_o
  );
endinterface

// File: rtl/iq_word_packer.sv
// Packs interleaved real/imag samples into {real, imag} words behind a 2-entry FIFO.
// Optional build macro IQPACK_ERRCNT_EN adds an 8-bit saturating realign counter errcnt_o.
module iq_word_packer #(
  parameter int WIDTH_IN_WORD = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  iq_word_packer_if.slave  bus
`ifdef IQPACK_ERRCNT_EN
  ,
  output logic [7:0]       errcnt_o
`endif
);

  localparam int SW = WIDTH_IN_WORD >> 1;

  if ((WIDTH_IN_WORD < 4) || ((WIDTH_IN_WORD % 2) != 0)) begin : g_bad_width
    $error("iq_word_packer: WIDTH_IN_WORD must be even and >= 4");
  end

  typedef enum logic {
    WAIT_RE = 1'b0,
    WAIT_IM = 1'b1
  } state_e;

  state_e                   state_q, state_d;
  logic [SW-1:0]            real_q;
  logic [WIDTH_IN_WORD-1:0] mem_q [2];
  logic                     rd_ptr_q, wr_ptr_q;
  logic [1:0]               count_q;
  logic                     realign_q;

  logic accept, pop, push, load_real, realign_d;

  // Ready depends only on registered state, never on RIword_ready_i.
  assign bus.sample_ready_o = (state_q == WAIT_RE) || (count_q < 2'd2);
  assign accept             = bus.sample_valid_i & bus.sample_ready_o;
  assign bus.RIword_valid_o = (count_q != 2'd0);
  assign pop                = bus.RIword_valid_o & bus.RIword_ready_i;

  assign bus.RIword_o  = mem_q[rd_ptr_q];
  assign bus.phase_o   = (state_q == WAIT_IM);
  assign bus.realign_o = realign_q;

  // NOTE: every output of this block gets a default before any branch, so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    push      = 1'b0;
    load_real = 1'b0;
    realign_d = 1'b0;
    if (accept) begin
      case (state_q)
        WAIT_RE: begin
          load_real = 1'b1;
          state_d   = WAIT_IM;
        end
        WAIT_IM: begin
          if (bus.sof_i) begin
            load_real = 1'b1;
            realign_d = 1'b1;
          end else begin
            push    = 1'b1;
            state_d = WAIT_RE;
          end
        end
        default: state_d = WAIT_RE;
      endcase
    end
    if (clr_i) begin
      state_d   = WAIT_RE;
      push      = 1'b0;
      load_real = 1'b0;
      realign_d = 1'b0;
    end
  end

  // NOTE: sequential state is updated with <= so all registers see pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= WAIT_RE;
      realign_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      realign_q <= realign_d;
    end
  end

  // NOTE: the real holding register is pure data qualified by state, so it carries no reset.
  always_ff @(posedge clk_i) begin
    if (load_real) begin
      real_q <= bus.sample_i;
    end
  end

  // NOTE: the two FIFO slots are reset because the head must read as zero out of reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (clr_i) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= {real_q, bus.sample_i};
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef IQPACK_ERRCNT_EN
  logic [7:0] errcnt_q;

  // realign_d is already suppressed under clr_i, so a clearing cycle never counts.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      errcnt_q <= 8'd0;
    end else if (clr_i) begin
      errcnt_q <= 8'd0;
    end else if (realign_d && (errcnt_q != 8'hFF)) begin
      errcnt_q <= errcnt_q + 8'd1;
    end
  end

  assign errcnt_o = errcnt_q;
`endif

endmodule
